mtr_drv: RTL and testbench

Motor drive stage downstream of the balance controller. Consumes the signed 12-bit `lft_spd`/`rght_spd` commands and produces H-bridge PWM pairs for the left and right motors. Each motor gets a per-period slew limit and a dead period on direction reversal. A shared 11-bit free-running PWM counter gives one 2048-clock period; commands are sampled only at period boundaries, so duty never changes mid-period.

---
 rtl/segway_pkg.sv | 26 ++
 rtl/mtr_chan.sv | 77 +++++++
 rtl/mtr_drv.sv | 63 ++++++
 tb/tb_mtr_drv.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/segway_pkg.sv
// Shared types and constants for the segway drive path.
// Speeds are signed 12-bit; PWM period is 2^PWM_W clocks.
package segway_pkg;

    localparam int PWM_W   = 11;
    localparam int SPD_W   = 12;
    localparam int SPD_MAX = 2047;

    typedef logic signed [SPD_W-1:0] spd_t;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_t;

    // Fold -2048 onto -2047 so the magnitude always fits in PWM_W bits.
    function automatic spd_t sat_spd(input spd_t s);
        spd_t r;
        if (s == {1'b1, {(SPD_W-1){1'b0}}})
            r = spd_t'(-SPD_MAX);
        else
            r = s;
        return r;
    endfunction

endpackage

// File: rtl/mtr_chan.sv
// One motor channel: saturate, slew-limit and reverse-protect the command
// once per period, then compare the magnitude against the shared counter.
module mtr_chan
    import segway_pkg::*;
#(
    parameter int MAX_STEP = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] cnt,
    input  logic             upd,
    input  spd_t             tgt,
    output logic             fwd_out,
    output logic             rev_out
);

    localparam logic signed [SPD_W:0] STEP = (SPD_W+1)'(MAX_STEP);

    spd_t                    app_q;
    spd_t                    app_d;
    dir_t                    dir_q;
    dir_t                    dir_d;
    logic                    dead_q;
    logic                    dead_d;
    spd_t                    tgt_sat;
    logic signed [SPD_W:0]   tgt_w;
    logic signed [SPD_W:0]   app_w;
    logic signed [SPD_W:0]   hi_w;
    logic signed [SPD_W:0]   lo_w;
    logic signed [SPD_W:0]   new_w;
    logic [SPD_W-1:0]        mag;
    logic                    on;

    assign tgt_sat = sat_spd(tgt);

    // Slew in 13 bits so app +/- STEP cannot wrap.
    always_comb begin
        tgt_w  = {tgt_sat[SPD_W-1], tgt_sat};
        app_w  = {app_q[SPD_W-1], app_q};
        hi_w   = app_w + STEP;
        lo_w   = app_w - STEP;
        new_w  = tgt_w;
        if (tgt_w > hi_w)
            new_w = hi_w;
        else if (tgt_w < lo_w)
            new_w = lo_w;
        app_d  = spd_t'(new_w);
        dir_d  = dir_q;
        dead_d = 1'b0;
        if (app_d != '0 && dir_t'(app_d[SPD_W-1]) != dir_q) begin
            dead_d = 1'b1;
            dir_d  = dir_t'(app_d[SPD_W-1]);
        end
    end

    assign mag = app_q[SPD_W-1] ? -app_q : app_q;
    assign on  = !dead_q && ({1'b0, cnt} < mag);

    always_ff @(posedge clk) begin
        if (rst) begin
            app_q   <= '0;
            dir_q   <= DIR_FWD;
            dead_q  <= 1'b0;
            fwd_out <= 1'b0;
            rev_out <= 1'b0;
        end else begin
            if (upd) begin
                app_q  <= app_d;
                dir_q  <= dir_d;
                dead_q <= dead_d;
            end
            fwd_out <= on && (dir_q == DIR_FWD);
            rev_out <= on && (dir_q == DIR_REV);
        end
    end

endmodule

// File: rtl/mtr_drv.sv
// Dual H-bridge PWM driver: shared period counter, power gating of the
// targets, and one mtr_chan per motor (index 0 = left, 1 = right).
module mtr_drv
    import segway_pkg::*;
#(
    parameter int MAX_STEP = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pwr_up,
    input  logic signed [SPD_W-1:0] lft_spd,
    input  logic signed [SPD_W-1:0] rght_spd,
    output logic                    lft_fwd,
    output logic                    lft_rev,
    output logic                    rght_fwd,
    output logic                    rght_rev,
    output logic                    prd_strt
);

    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W-1:0] cnt_d;
    logic             upd;
    spd_t             tgt [2];
    logic             fwd [2];
    logic             rev [2];

    assign cnt_d = cnt_q + 1'b1;
    assign upd   = (cnt_q == {PWM_W{1'b1}});

    // With power down both channels slew toward zero rather than cutting off.
    assign tgt[0] = pwr_up ? lft_spd  : '0;
    assign tgt[1] = pwr_up ? rght_spd : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            prd_strt <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            prd_strt <= upd;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        mtr_chan #(
            .MAX_STEP(MAX_STEP)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .cnt    (cnt_q),
            .upd    (upd),
            .tgt    (tgt[gi]),
            .fwd_out(fwd[gi]),
            .rev_out(rev[gi])
        );
    end

    assign lft_fwd  = fwd[0];
    assign lft_rev  = rev[0];
    assign rght_fwd = fwd[1];
    assign rght_rev = rev[1];

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: step-64 and step-512 instances, per-period pulse widths
// checked by a monitor against a scoreboard queue filled by the stimulus.
module tb_mtr_drv;

    logic clk = 1'b0;
    logic rst;
    logic pwr_up;
    logic signed [11:0] lft_spd, rght_spd, s_lft_spd, s_rght_spd;
    logic lft_fwd, lft_rev, rght_fwd, rght_rev, prd_strt;
    logic s_lft_fwd, s_lft_rev, s_rght_fwd, s_rght_rev, s_prd_strt;
    logic [7:0] outs;

    int n_checks = 0;
    int n_errors = 0;
    logic [95:0] exp_q [$];
    logic [95:0] tab [1:24];

    always #5 clk = ~clk;

    mtr_drv #(.MAX_STEP(64)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .pwr_up  (pwr_up),
        .lft_spd (lft_spd),
        .rght_spd(rght_spd),
        .lft_fwd (lft_fwd),
        .lft_rev (lft_rev),
        .rght_fwd(rght_fwd),
        .rght_rev(rght_rev),
        .prd_strt(prd_strt)
    );

    mtr_drv #(.MAX_STEP(512)) u_sat (
        .clk     (clk),
        .rst     (rst),
        .pwr_up  (pwr_up),
        .lft_spd (s_lft_spd),
        .rght_spd(s_rght_spd),
        .lft_fwd (s_lft_fwd),
        .lft_rev (s_lft_rev),
        .rght_fwd(s_rght_fwd),
        .rght_rev(s_rght_rev),
        .prd_strt(s_prd_strt)
    );

    assign outs = {s_rght_rev, s_rght_fwd, s_lft_rev, s_lft_fwd,
                   rght_rev, rght_fwd, lft_rev, lft_fwd};

    // Expected high widths: main lf, lr, rf, rr, then step-512 lf, lr, rf, rr.
    function automatic logic [95:0] mk(int a, int b, int c, int d,
                                       int e, int f, int g, int h);
        logic [95:0] v;
        v = {12'(h), 12'(g), 12'(f), 12'(e), 12'(d), 12'(c), 12'(b), 12'(a)};
        return v;
    endfunction

    task automatic wait_prd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!prd_strt && n < 2100);
        n_checks++;
        if (!prd_strt) begin
            n_errors++;
            $display("FAIL prd_timeout: no prd_strt after %0d cycles, required within 2048", n);
        end
    endtask

    // Monitor: a window runs from one prd_strt cycle to the cycle before the next.
    initial begin : monitor
        int cnt_w [8];
        int ovl;
        int win;
        bit started;
        logic [95:0] e;
        string nm [8];
        nm = '{"lft_fwd", "lft_rev", "rght_fwd", "rght_rev",
               "s_lft_fwd", "s_lft_rev", "s_rght_fwd", "s_rght_rev"};
        started = 1'b0;
        win = 0;
        ovl = 0;
        for (int i = 0; i < 8; i++) cnt_w[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                started = 1'b0;
            end else begin
                if (prd_strt) begin
                    if (started) begin
                        win++;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL sb_underflow win %0d: got a period, required a queued expectation", win);
                        end else begin
                            e = exp_q.pop_front();
                            $display("win %0d widths lf=%0d lr=%0d rf=%0d rr=%0d slf=%0d slr=%0d srf=%0d srr=%0d",
                                     win, cnt_w[0], cnt_w[1], cnt_w[2], cnt_w[3],
                                     cnt_w[4], cnt_w[5], cnt_w[6], cnt_w[7]);
                            for (int i = 0; i < 8; i++) begin
                                n_checks++;
                                if (cnt_w[i] != int'(e[12*i +: 12])) begin
                                    n_errors++;
                                    $display("FAIL width_%s win %0d: got %0d, expected %0d",
                                             nm[i], win, cnt_w[i], e[12*i +: 12]);
                                end
                            end
                            n_checks++;
                            if (ovl != 0) begin
                                n_errors++;
                                $display("FAIL overlap win %0d: got %0d cycles with fwd&rev, expected 0", win, ovl);
                            end
                        end
                    end
                    started = 1'b1;
                    ovl = 0;
                    for (int i = 0; i < 8; i++) cnt_w[i] = 0;
                end
                if (started) begin
                    for (int i = 0; i < 8; i++) cnt_w[i] += int'(outs[i]);
                    if ((outs[0] && outs[1]) || (outs[2] && outs[3]) ||
                        (outs[4] && outs[5]) || (outs[6] && outs[7]))
                        ovl++;
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        int highs;
        rst        = 1'b1;
        pwr_up     = 1'b1;
        lft_spd    = '0;
        rght_spd   = '0;
        s_lft_spd  = '0;
        s_rght_spd = '0;

        tab[1]  = mk(0,   0, 0, 0,   0, 0, 0, 0);
        tab[2]  = mk(0,   0, 0, 0,   0, 0, 0, 0);
        tab[3]  = mk(0,   0, 0, 0,   0, 0, 0, 0);
        tab[4]  = mk(64,  0, 0, 0,   0, 0, 0, 0);
        tab[5]  = mk(128, 0, 0, 128, 0, 0, 0, 1024);
        tab[6]  = mk(192, 0, 0, 192, 0, 0, 0, 1536);
        tab[7]  = mk(256, 0, 0, 256, 0, 0, 0, 2047);
        tab[8]  = mk(300, 0, 0, 320, 0, 0, 0, 2047);
        tab[9]  = mk(300, 0, 0, 384, 0, 0, 0, 2047);
        tab[10] = mk(364, 0, 0, 448, 0, 0, 0, 2047);
        tab[11] = mk(428, 0, 0, 512, 0, 0, 0, 2047);
        tab[12] = mk(492, 0, 0, 576, 0, 0, 0, 2047);
        tab[13] = mk(500, 0, 0, 640, 0, 0, 0, 2047);
        tab[14] = mk(436, 0, 0, 576, 0, 0, 0, 1535);
        tab[15] = mk(372, 0, 0, 512, 0, 0, 0, 1023);
        tab[16] = mk(308, 0, 0, 448, 0, 0, 0, 511);
        tab[17] = mk(244, 0, 0, 384, 0, 0, 0, 0);
        tab[18] = mk(180, 0, 0, 320, 0, 0, 0, 0);
        tab[19] = mk(116, 0, 0, 256, 0, 0, 0, 0);
        tab[20] = mk(52,  0, 0, 192, 0, 0, 0, 0);
        tab[21] = mk(0,   0, 0, 128, 0, 0, 0, 0);
        tab[22] = mk(40,  0, 0, 192, 0, 0, 0, 512);
        tab[23] = mk(0,   0, 0, 256, 0, 0, 0, 1024);
        tab[24] = mk(0,  40, 0, 320, 0, 0, 0, 1536);

        repeat (3) @(negedge clk);
        n_checks++;
        if ({outs, prd_strt} != 9'd0) begin
            n_errors++;
            $display("FAIL reset_state: got %b, expected all zero", {outs, prd_strt});
        end
        $display("reset released");
        rst = 1'b0;

        for (int k = 1; k <= 24; k++) begin
            wait_prd();
            exp_q.push_back(tab[k]);
            case (k)
                3: begin
                    lft_spd    = 12'sd300;
                    rght_spd   = 12'sh800;
                    s_rght_spd = 12'sh800;
                end
                9: begin
                    repeat (1000) @(negedge clk);
                    lft_spd = 12'sd500;
                end
                13: pwr_up = 1'b0;
                21: begin
                    pwr_up  = 1'b1;
                    lft_spd = 12'sd40;
                end
                22: lft_spd = -12'sd40;
                default: ;
            endcase
        end

        // Abandon a period with reset at cnt = 700.
        wait_prd();
        repeat (700) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({outs, prd_strt} != 9'd0) begin
            n_errors++;
            $display("FAIL rst_mid: got %b, expected all zero", {outs, prd_strt});
        end
        lft_spd = 12'sd500;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        highs = 0;
        do begin
            @(negedge clk);
            n++;
            if (!prd_strt) highs += $countones(outs);
        end while (!prd_strt && n < 2100);
        n_checks++;
        if (n != 2048) begin
            n_errors++;
            $display("FAIL cnt_restart: got prd_strt after %0d cycles, expected 2048", n);
        end
        n_checks++;
        if (highs != 0) begin
            n_errors++;
            $display("FAIL first_period: got %0d high cycles, expected 0", highs);
        end
        $display("post-reset period done after %0d cycles", n);
        exp_q.push_back(mk(64, 0, 0, 0, 0, 0, 0, 0));
        wait_prd();
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
